icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
Parametrised set-associative instruction cache. It sits between the datapath fetch port and the memory controller's instruction channel, and is the successor to the direct-mapped one-word-per-frame icache. It adds configurable sets, ways and multi-word blocks, with sequential block fill, per-set round-robin replacement and a multi-cycle full-cache flush.

Parameters:
NSETS, 8, number of sets; power of 2, >=2
NWAYS, 2, ways per set; power of 2, >=1
BLKWORDS, 2, 32-bit words per block; power of 2, >=1

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
imemREN  in  1  datapath fetch request
imemaddr  in  32  datapath fetch byte address; bits[1:0] ignored
ihit  out  1  fetch data valid this cycle
imemload  out  32  fetched instruction; 0 when ihit=0
flush  in  1  invalidate-all request, sampled on the clock edge
flush_done  out  1  one-cycle pulse when invalidation completes
iREN  out  1  memory read request
iaddr  out  32  memory word address
iwait  in  1  memory busy; iload valid in any cycle where iREN=1 and iwait=0
iload  in  32  memory read data

Behaviour:
- Address split: OB=log2(BLKWORDS), IB=log2(NSETS). Word offset = addr[2+OB-1:2]; index = addr[2+OB+IB-1:2+OB]; tag = addr[31:2+OB+IB].
- Storage per set: NWAYS x {valid, tag, BLKWORDS data words}, plus a log2(NWAYS)-bit round-robin pointer rr.
- Asynchronous reset: all valid=0, all rr=0, state=LOOKUP, fill counter=0, flush counter=0, flush pending=0. Outputs: ihit=0, imemload=0, iREN=0, iaddr=0, flush_done=0. Reset mid-fill aborts the fill; iREN falls immediately.
- States: LOOKUP, FILL, FLUSH.
- LOOKUP:
  - Hit = imemREN & a valid way in the indexed set with a matching tag.
  - Hit is combinational, zero latency: ihit=1, imemload = that way's word[offset]. iREN=0.
  - On miss with imemREN=1, latch {tag, index} and select a victim: the lowest-index invalid way, otherwise way rr. Clear the fill counter and go to FILL next cycle.
  - imemREN=0: no hit, no state change.
- FILL:
  - iREN=1; iaddr = {latched tag, latched index, fill counter, 2'b00}. Words are fetched from word 0 upward regardless of the requested offset.
  - Each cycle with iwait=0: write iload into victim word[counter] and increment the counter.
  - When the last word is accepted: set victim valid=1 and tag=latched tag; advance rr of that set by 1 modulo NWAYS only if the victim was chosen by rr; return to LOOKUP.
  - The requesting fetch hits on the first LOOKUP cycle after the fill, if imemaddr is unchanged.
  - ihit=0 throughout FILL. Changes to imemaddr or imemREN during FILL are ignored; the fill always completes.
  - Victim valid is cleared in the first FILL cycle, so a partially filled block never hits.
- Flush:
  - flush=1 in LOOKUP, or a pending flush on FILL completion, enters FLUSH with the counter at 0.
  - flush=1 during FILL sets flush pending; the fill completes first, then FLUSH is entered directly, skipping LOOKUP.
  - FLUSH clears valid for all ways of set[counter] and resets rr to 0, one set per cycle, for NSETS cycles.
  - flush_done=1 in the last FLUSH cycle; LOOKUP follows.
  - ihit=0 and iREN=0 throughout FLUSH. flush=1 while in FLUSH is ignored.
- Simultaneous flush=1 and miss in LOOKUP: flush wins and no fill starts. The fetch is re-evaluated after the flush.
- NWAYS=1: rr is absent or constant 0, and the block behaves as direct-mapped.
- A memory response with iwait=0 is consumed only in FILL.

Test Plan:
All scenarios use defaults (tag=[31:6], index=[5:3], offset=[2]) and memory returning data equal to the address.
1. Cold miss: imemREN=1, imemaddr=0x44, iwait high 2 cycles per word -> iREN=1 with iaddr=0x40 then 0x44. Next LOOKUP cycle: ihit=1, imemload=0x44. Then imemaddr=0x40 -> ihit same cycle, imemload=0x40, iREN=0.
2. Associativity and replacement: fill 0x00 (way0) and 0x40 (way1), both hit. Then 0x80 misses and evicts way0 (rr=0), rr becomes 1. Then 0x40 hits, 0x00 misses and evicts way1 (0x40).
3. Flush: after scenario 1, pulse flush -> ihit=0 for 8 cycles, flush_done pulses in the 8th cycle. Then 0x44 misses and refills.
4. Flush during fill: assert flush in the second FILL cycle -> both words are fetched, then FLUSH runs 8 cycles. The filled line is invalid afterwards.
5. Address change mid-fill: miss on 0x48, then change imemaddr to 0x100 during FILL -> iaddr stays 0x48/0x4C. After the fill, 0x100 misses and starts a new fill.
6. Reset mid-fill: drop nRST during FILL -> iREN=0 and ihit=0 immediately. After release, 0x40 misses.

Source files
------------

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signals of the set-associative instruction cache.
// The slave modport is the cache's view; the master modport is the environment's view.
interface icache_assoc_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        flush_done;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, flush_done, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, flush_done, iREN, iaddr
  );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: zero-latency hits, sequential block fill,
// per-set round-robin replacement and a one-set-per-cycle flush.
module icache_assoc #(
  parameter int NSETS    = 8,
  parameter int NWAYS    = 2,
  parameter int BLKWORDS = 2
) (
  input  logic           CLK,
  input  logic           nRST,
  icache_assoc_if.slave  cif
);
  localparam int OB  = $clog2(BLKWORDS);
  localparam int IB  = $clog2(NSETS);
  localparam int WB  = $clog2(NWAYS);
  localparam int OBW = (OB > 0) ? OB : 1;
  localparam int WBW = (WB > 0) ? WB : 1;
  localparam int TB  = 32 - 2 - OB - IB;

  typedef enum logic [1:0] {LOOKUP, FILL, FLUSH} state_t;

  state_t           state_q;
  logic [OBW-1:0]   fcnt_q;
  logic [IB-1:0]    scnt_q;
  logic             pend_q;
  logic [TB-1:0]    ftag_q;
  logic [IB-1:0]    fidx_q;
  logic [WBW-1:0]   victim_q;
  logic             use_rr_q;

  logic [NWAYS-1:0] valid_q [NSETS];
  logic [WBW-1:0]   rr_q    [NSETS];
  logic [TB-1:0]    tag_q   [NSETS][NWAYS];
  logic [31:0]      data_q  [NSETS][NWAYS][BLKWORDS];

  logic [OBW-1:0]   req_off;
  logic [IB-1:0]    req_idx;
  logic [TB-1:0]    req_tag;
  logic [NWAYS-1:0] way_hit;
  logic             hit_any;
  logic [WBW-1:0]   hit_way;
  logic             inv_found;
  logic [WBW-1:0]   inv_way;
  logic [WBW-1:0]   vict_way;
  logic             lookup_hit;
  logic             fill_last;
  logic             unused_addr_bits;

  assign req_idx          = cif.imemaddr[2+OB +: IB];
  assign req_tag          = cif.imemaddr[2+OB+IB +: TB];
  assign unused_addr_bits = ^cif.imemaddr[1:0];

  generate
    if (OB > 0) begin : g_off
      assign req_off = cif.imemaddr[2 +: OBW];
    end else begin : g_no_off
      assign req_off = '0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NWAYS; gi++) begin : g_way_cmp
      assign way_hit[gi] = valid_q[req_idx][gi] && (tag_q[req_idx][gi] == req_tag);
    end
  endgenerate

  // Downward scan so the lowest-index invalid way wins the victim choice.
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (way_hit[w]) begin
        hit_any = 1'b1;
        hit_way = WBW'(w);
      end
    end
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WBW'(w);
      end
    end
  end

  assign vict_way   = inv_found ? inv_way : rr_q[req_idx];
  assign lookup_hit = (state_q == LOOKUP) && cif.imemREN && hit_any;
  assign fill_last  = (state_q == FILL) && !cif.iwait && (fcnt_q == OBW'(BLKWORDS - 1));

  assign cif.ihit       = lookup_hit;
  assign cif.imemload   = lookup_hit ? data_q[req_idx][hit_way][req_off] : 32'h0;
  assign cif.iREN       = (state_q == FILL);
  assign cif.iaddr      = (state_q == FILL)
                        ? ({ftag_q, fidx_q, {(OB+2){1'b0}}} | (32'(fcnt_q) << 2))
                        : 32'h0;
  assign cif.flush_done = (state_q == FLUSH) && (scnt_q == IB'(NSETS - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= LOOKUP;
      fcnt_q   <= '0;
      scnt_q   <= '0;
      pend_q   <= 1'b0;
      ftag_q   <= '0;
      fidx_q   <= '0;
      victim_q <= '0;
      use_rr_q <= 1'b0;
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      case (state_q)
        LOOKUP: begin
          if (cif.flush) begin
            state_q <= FLUSH;
            scnt_q  <= '0;
          end else if (cif.imemREN && !hit_any) begin
            ftag_q   <= req_tag;
            fidx_q   <= req_idx;
            victim_q <= vict_way;
            use_rr_q <= !inv_found;
            fcnt_q   <= '0;
            // Invalidate up front so a half-written block can never hit.
            valid_q[req_idx][vict_way] <= 1'b0;
            state_q  <= FILL;
          end
        end
        FILL: begin
          if (cif.flush) pend_q <= 1'b1;
          if (!cif.iwait) fcnt_q <= fcnt_q + OBW'(1);
          if (fill_last) begin
            fcnt_q <= '0;
            valid_q[fidx_q][victim_q] <= 1'b1;
            if (use_rr_q && (NWAYS > 1)) rr_q[fidx_q] <= rr_q[fidx_q] + WBW'(1);
            if (pend_q || cif.flush) begin
              state_q <= FLUSH;
              scnt_q  <= '0;
              pend_q  <= 1'b0;
            end else begin
              state_q <= LOOKUP;
            end
          end
        end
        FLUSH: begin
          valid_q[scnt_q] <= '0;
          rr_q[scnt_q]    <= '0;
          if (scnt_q == IB'(NSETS - 1)) begin
            scnt_q  <= '0;
            state_q <= LOOKUP;
          end else begin
            scnt_q <= scnt_q + IB'(1);
          end
        end
        default: state_q <= LOOKUP;
      endcase
    end
  end

  // Tags and data carry no reset; the valid bits guard them.
  always_ff @(posedge CLK) begin
    if ((state_q == FILL) && !cif.iwait) data_q[fidx_q][victim_q][fcnt_q] <= cif.iload;
    if (fill_last) tag_q[fidx_q][victim_q] <= ftag_q;
  end
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: table of fetches plus hand-written flush and reset sequences.
// Memory returns data equal to the word address; iwait stretches each word by a per-fetch count.
module tb_icache_assoc;
  logic CLK;
  logic nRST;
  int   checks = 0;
  int   failures = 0;
  int   wait_cycles = 0;
  int   wcnt = 0;

  icache_assoc_if bus();

  icache_assoc #(.NSETS(8), .NWAYS(2), .BLKWORDS(2)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .cif  (bus)
  );

  assign bus.iload = bus.iaddr;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory responder: wait_cycles busy cycles, then one accepting cycle, per word.
  initial begin
    bus.iwait = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.iREN) begin
        if (wcnt < wait_cycles) begin
          bus.iwait = 1'b1;
          wcnt++;
        end else begin
          bus.iwait = 1'b0;
          wcnt = 0;
        end
      end else begin
        bus.iwait = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One fetch: checks hit/miss now; on a miss follows the fill word by word,
  // then checks the post-fill lookup (optionally after moving imemaddr to alt mid-fill).
  task automatic do_fetch(input logic [31:0] addr, input bit exp_miss, input int waitc,
                          input logic [31:0] alt);
    logic [31:0] base;
    int          nacc;
    bit          seen;
    bit          done;
    bit          hitdur;
    wait_cycles = waitc;
    @(negedge CLK);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    #1;
    chk($sformatf("ihit@%h", addr), {31'b0, bus.ihit}, {31'b0, !exp_miss});
    nacc = 0;
    if (!exp_miss) begin
      chk($sformatf("imemload@%h", addr), bus.imemload, addr);
    end else begin
      base   = addr & ~32'h7;
      seen   = 1'b0;
      done   = 1'b0;
      hitdur = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        if (c == 1 && alt != 32'h0) bus.imemaddr = alt;
        if (bus.iREN) begin
          seen = 1'b1;
          if (bus.ihit) hitdur = 1'b1;
          if (!bus.iwait) begin
            chk($sformatf("iaddr@%h.w%0d", addr, nacc), bus.iaddr, base + 32'(4 * nacc));
            nacc++;
          end
        end else if (seen) begin
          done = 1'b1;
        end
        if (!done) begin
          @(negedge CLK);
          #1;
        end
      end
      chk($sformatf("fill_end@%h", addr), {31'b0, done}, 32'd1);
      chk($sformatf("words@%h", addr), nacc, 32'd2);
      chk($sformatf("ihit_in_fill@%h", addr), {31'b0, hitdur}, 32'd0);
      chk($sformatf("post_ihit@%h", addr), {31'b0, bus.ihit}, {31'b0, alt == 32'h0});
      if (alt == 32'h0) chk($sformatf("post_load@%h", addr), bus.imemload, addr);
    end
    $display("txn addr=%h miss=%0d wait=%0d words=%0d", addr, exp_miss, waitc, nacc);
  endtask

  // Called at the sample point of the first FLUSH cycle.
  task automatic check_flush_window(input string tagname);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s.ihit%0d", tagname, k), {31'b0, bus.ihit}, 32'd0);
      chk($sformatf("%s.iREN%0d", tagname, k), {31'b0, bus.iREN}, 32'd0);
      chk($sformatf("%s.done%0d", tagname, k), {31'b0, bus.flush_done}, {31'b0, k == 7});
      if (k < 7) begin
        @(negedge CLK);
        #1;
      end
    end
    $display("txn flush window %s", tagname);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    int          waitc;
    logic [31:0] alt;
  } vec_t;

  vec_t vecs [18];

  initial begin
    int nacc;
    vecs[0]  = '{32'h44,  1'b1, 2, 32'h0};
    vecs[1]  = '{32'h40,  1'b0, 0, 32'h0};
    vecs[2]  = '{32'h00,  1'b1, 0, 32'h0};
    vecs[3]  = '{32'h44,  1'b0, 0, 32'h0};
    vecs[4]  = '{32'h04,  1'b0, 0, 32'h0};
    vecs[5]  = '{32'h80,  1'b1, 1, 32'h0};
    vecs[6]  = '{32'h00,  1'b0, 0, 32'h0};
    vecs[7]  = '{32'h40,  1'b1, 0, 32'h0};
    vecs[8]  = '{32'h84,  1'b0, 0, 32'h0};
    vecs[9]  = '{32'h44,  1'b0, 0, 32'h0};
    vecs[10] = '{32'h00,  1'b1, 0, 32'h0};
    vecs[11] = '{32'h80,  1'b1, 0, 32'h0};
    vecs[12] = '{32'h04,  1'b0, 0, 32'h0};
    vecs[13] = '{32'h48,  1'b1, 1, 32'h100};
    vecs[14] = '{32'h100, 1'b1, 0, 32'h0};
    vecs[15] = '{32'h4C,  1'b0, 0, 32'h0};
    vecs[16] = '{32'h84,  1'b0, 0, 32'h0};
    vecs[17] = '{32'h00,  1'b1, 0, 32'h0};

    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0;
    bus.flush    = 1'b0;
    #12;
    chk("rst.ihit", {31'b0, bus.ihit}, 32'd0);
    chk("rst.imemload", bus.imemload, 32'h0);
    chk("rst.iREN", {31'b0, bus.iREN}, 32'd0);
    chk("rst.iaddr", bus.iaddr, 32'h0);
    chk("rst.flush_done", {31'b0, bus.flush_done}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 18; i++)
      do_fetch(vecs[i].addr, vecs[i].miss, vecs[i].waitc, vecs[i].alt);

    // Flush coinciding with a miss: flush wins, nothing is fetched.
    @(negedge CLK);
    bus.imemaddr = 32'h44;
    bus.flush    = 1'b1;
    #1;
    chk("flush.miss_ihit", {31'b0, bus.ihit}, 32'd0);
    @(negedge CLK);
    bus.flush = 1'b0;
    #1;
    check_flush_window("flush");
    do_fetch(32'h44, 1'b1, 0, 32'h0);

    // Flush raised in the second FILL cycle: fill completes, then straight into FLUSH.
    wait_cycles = 1;
    @(negedge CLK);
    bus.imemaddr = 32'h48;
    #1;
    chk("fdf.ihit", {31'b0, bus.ihit}, 32'd0);
    nacc = 0;
    for (int c = 1; c < 100; c++) begin
      @(negedge CLK);
      #1;
      if (c == 2) bus.flush = 1'b1;
      if (c == 3) bus.flush = 1'b0;
      if (!bus.iREN) break;
      if (!bus.iwait) nacc++;
    end
    bus.flush = 1'b0;
    chk("fdf.words", nacc, 32'd2);
    check_flush_window("fdf");
    do_fetch(32'h48, 1'b1, 0, 32'h0);

    // Reset dropped mid-fill.
    wait_cycles = 3;
    @(negedge CLK);
    bus.imemaddr = 32'h40;
    #1;
    chk("rmf.ihit", {31'b0, bus.ihit}, 32'd0);
    @(negedge CLK);
    #1;
    chk("rmf.iREN_fill", {31'b0, bus.iREN}, 32'd1);
    chk("rmf.iaddr_fill", bus.iaddr, 32'h40);
    #2;
    nRST = 1'b0;
    #1;
    chk("rmf.iREN_rst", {31'b0, bus.iREN}, 32'd0);
    chk("rmf.ihit_rst", {31'b0, bus.ihit}, 32'd0);
    chk("rmf.iaddr_rst", bus.iaddr, 32'h0);
    $display("txn reset mid-fill");
    @(negedge CLK);
    nRST = 1'b1;
    do_fetch(32'h40, 1'b1, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
